// File: rtl/lsu_req_if.sv
// Purpose : sram-like data-memory request/response channel between lsu_req and the data memory.
// Latency : wires only; timing is set by the master (lsu_req) and the memory slave.
// Backpressure: the slave holds off a request by withholding data_addr_ok; data_data_ok returns read data.
// Ports   : master drives data_req/data_wr/data_size/data_addr/data_wdata/data_wstrb and
//           receives data_addr_ok/data_data_ok/data_rdata; slave is the mirror image.
`timescale 1ns/1ps

interface lsu_req_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/lsu_req.sv
// Purpose : EX-stage load/store request generator; issues one sram-like access per memory
//           instruction and builds the EX->MEM pipeline bus.
// Latency : request one cycle after EX presents the access; MEM bus valid (en=1) the cycle after data_ok.
// Backpressure: stallreq freezes IF..EX while the access is outstanding; stall[3]=`Stop holds the DONE state.
// Ports   : clk/rst (sync, active-high); stall vector; EX-stage operands and writeback control;
//           dmem (lsu_req_if.master) memory channel; stallreq, ex_to_mem_bus, data_sram_rdata, adel, ades.
// Option  : define LSU_ALIGN_CHECK_EN to flag misaligned halfword/word accesses (adel/ades) and suppress them.
`timescale 1ns/1ps

`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif
`ifndef EX_TO_MEM_WD
`define EX_TO_MEM_WD 80
`endif

module lsu_req (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [`StallBus]          stall,
    input  logic                      mem_valid,
    input  logic [3:0]                ld_code,
    input  logic [1:0]                st_size,
    input  logic [31:0]               ex_pc,
    input  logic [31:0]               addr,
    input  logic [31:0]               st_data,
    input  logic [31:0]               alu_result,
    input  logic                      sel_rf_res,
    input  logic                      rf_we,
    input  logic [4:0]                rf_waddr,
    lsu_req_if.master                 dmem,
    output logic                      stallreq,
    output logic [`EX_TO_MEM_WD-1:0]  ex_to_mem_bus,
    output logic [31:0]               data_sram_rdata,
    output logic                      adel,
    output logic                      ades
);

    localparam logic [3:0] LD_NONE = 4'b0000;
    localparam logic [3:0] LD_LB   = 4'b0001;
    localparam logic [3:0] LD_LBU  = 4'b0010;
    localparam logic [3:0] LD_LH   = 4'b0011;
    localparam logic [3:0] LD_LHU  = 4'b0100;
    localparam logic [3:0] LD_LW   = 4'b1111;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Only bit 3 of the stall vector matters here; the rest belongs to other stages.
    logic unused_stall;
    assign unused_stall = ^stall;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic        is_store;
    logic        access;
    logic        fault;
    logic        adel_c;
    logic        ades_c;
    logic [1:0]  req_size;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;

    // A store code wins if both codes are (illegally) nonzero.
    assign is_store = (st_size != ST_NONE);
    assign access   = mem_valid && ((ld_code != LD_NONE) || is_store);

    always_comb begin
        req_size  = 2'd2;
        req_wstrb = 4'b0000;
        req_wdata = st_data;
        if (is_store) begin
            case (st_size)
                ST_SB: begin
                    req_size  = 2'd0;
                    req_wstrb = 4'b0001 << addr[1:0];
                    req_wdata = {4{st_data[7:0]}};
                end
                ST_SH: begin
                    req_size  = 2'd1;
                    req_wstrb = 4'b0011 << addr[1:0];
                    req_wdata = {2{st_data[15:0]}};
                end
                default: begin
                    req_size  = 2'd2;
                    req_wstrb = 4'b1111;
                    req_wdata = st_data;
                end
            endcase
        end else begin
            case (ld_code)
                LD_LB, LD_LBU: req_size = 2'd0;
                LD_LH, LD_LHU: req_size = 2'd1;
                default:       req_size = 2'd2;
            endcase
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    assign adel_c = access && !is_store &&
                    ((((ld_code == LD_LH) || (ld_code == LD_LHU)) && addr[0]) ||
                     ((ld_code == LD_LW) && (addr[1:0] != 2'b00)));
    assign ades_c = access && is_store &&
                    (((st_size == ST_SH) && addr[0]) ||
                     ((st_size == ST_SW) && (addr[1:0] != 2'b00)));
`else
    assign adel_c = 1'b0;
    assign ades_c = 1'b0;
`endif

    assign fault = adel_c || ades_c;
    assign adel  = adel_c && !rst;
    assign ades  = ades_c && !rst;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (access && !fault) state_nxt = REQ;
            REQ: begin
                // Memory may accept and answer in the same cycle: skip WAIT.
                if (dmem.data_addr_ok) state_nxt = dmem.data_data_ok ? DONE : WAIT;
            end
            WAIT: if (dmem.data_data_ok) state_nxt = DONE;
            DONE: if (stall[3] == `NoStop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    logic req_c;
    logic stall_c;
    logic done_c;
    logic capture_c;

    always_comb begin
        req_c     = 1'b0;
        stall_c   = 1'b0;
        done_c    = 1'b0;
        capture_c = 1'b0;
        case (state)
            IDLE: stall_c = access && !fault;
            REQ: begin
                req_c     = 1'b1;
                stall_c   = 1'b1;
                capture_c = dmem.data_addr_ok && dmem.data_data_ok;
            end
            WAIT: begin
                stall_c   = 1'b1;
                capture_c = dmem.data_data_ok;
            end
            DONE: done_c = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Request fields are frozen on issue so they stay stable through REQ.
    // ------------------------------------------------------------------
    logic        issue;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    assign issue = (state == IDLE) && access && !fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            wstrb_q <= 4'b0000;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (issue) begin
            wr_q    <= is_store;
            size_q  <= req_size;
            wstrb_q <= req_wstrb;
            addr_q  <= {addr[31:2], 2'b00};
            wdata_q <= req_wdata;
        end
    end

    assign dmem.data_req   = req_c && !rst;
    assign dmem.data_wr    = req_c && !rst && wr_q;
    assign dmem.data_wstrb = (req_c && !rst) ? wstrb_q : 4'b0000;
    assign dmem.data_size  = size_q;
    assign dmem.data_addr  = addr_q;
    assign dmem.data_wdata = wdata_q;

    assign stallreq = stall_c && !rst;

    // ------------------------------------------------------------------
    // Load data capture; only a data_ok seen in REQ/WAIT updates it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sram_rdata <= 32'd0;
        end else if (capture_c) begin
            data_sram_rdata <= dmem.data_rdata;
        end
    end

    // ------------------------------------------------------------------
    // EX->MEM bus. Memory fields are live only in DONE; the pipeline is
    // frozen until then, so EX operands are still the issuing instruction.
    // ------------------------------------------------------------------
    logic [3:0]  bus_readen;
    logic        bus_en;
    logic [3:0]  bus_wen;
    logic [31:0] bus_result;

    assign bus_en     = done_c;
    assign bus_readen = done_c ? ld_code   : 4'b0000;
    assign bus_wen    = done_c ? req_wstrb : 4'b0000;
    assign bus_result = done_c ? addr      : alu_result;

    assign ex_to_mem_bus = {bus_readen, ex_pc, bus_en, bus_wen,
                            sel_rf_res, rf_we && !fault, rf_waddr, bus_result};

endmodule

// File: tb/tb_lsu_req.sv
// Purpose : self-checking bench for lsu_req with a scoreboard of expected memory requests/read data.
// Latency : drives inputs 1ns after the rising edge, samples DUT outputs on the falling edge.
// Backpressure: a scripted memory responder delays data_addr_ok/data_data_ok per scenario.
`timescale 1ns/1ps

`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

module tb_lsu_req;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [`StallBus]  stall;
    logic              mem_valid;
    logic [3:0]        ld_code;
    logic [1:0]        st_size;
    logic [31:0]       ex_pc, addr, st_data, alu_result;
    logic              sel_rf_res, rf_we;
    logic [4:0]        rf_waddr;
    logic              stallreq;
    logic [79:0]       ex_to_mem_bus;
    logic [31:0]       data_sram_rdata;
    logic              adel, ades;

    lsu_req_if dif();

    lsu_req dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .mem_valid       (mem_valid),
        .ld_code         (ld_code),
        .st_size         (st_size),
        .ex_pc           (ex_pc),
        .addr            (addr),
        .st_data         (st_data),
        .alu_result      (alu_result),
        .sel_rf_res      (sel_rf_res),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .dmem            (dif),
        .stallreq        (stallreq),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .adel            (adel),
        .ades            (ades)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        wr;
        logic [31:0] rdata;
        logic [3:0]  readen;
        int          stall_cycles;
    } exp_t;

    typedef struct {
        bit          req_seen;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        wr;
        int          stall_cnt;
        int          done_cycles;
        int          done_req;
        logic [79:0] bus;
        bit          bus_stable;
        bit          flag;
        logic        post_en;
        logic        post_req;
        logic        post_stall;
        logic [31:0] rdata_after;
        bit          timeout;
    } obs_t;

    exp_t exp_q[$];

    // Drives one memory instruction through the DUT with a scripted memory.
    // aok_dly: REQ cycles before addr_ok; dok_dly: WAIT cycles before data_ok (-1 = same cycle as addr_ok).
    task automatic do_access(input logic [3:0] ld, input logic [1:0] st, input logic [31:0] a,
                             input logic [31:0] sd, input int aok_dly, input int dok_dly,
                             input logic [31:0] rd, input int hold, output obs_t o);
        int req_cyc = 0;
        int wcnt = 0;
        int phase = 0;
        o = '{default: 0};
        o.bus_stable = 1;
        for (int n = 0; n < 40 && phase < 3; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin
                mem_valid = 1'b1; ld_code = ld; st_size = st; addr = a; st_data = sd;
                alu_result = 32'hA1B2_C3D4; ex_pc = 32'hBFC0_0100;
                sel_rf_res = 1'b1; rf_we = 1'b1; rf_waddr = 5'd9;
                stall = '0;
                stall[3] = (hold > 0) ? `Stop : `NoStop;
            end
            if (hold > 0 && o.done_cycles == hold) stall[3] = `NoStop;
            dif.data_addr_ok = 1'b0;
            dif.data_data_ok = 1'b0;
            if (phase == 0 && dif.data_req) begin
                if (req_cyc == aok_dly) begin
                    dif.data_addr_ok = 1'b1;
                    if (dok_dly < 0) begin
                        dif.data_data_ok = 1'b1; dif.data_rdata = rd; phase = 2;
                    end else begin
                        phase = 1;
                    end
                end
                req_cyc++;
            end else if (phase == 1) begin
                if (wcnt == dok_dly) begin
                    dif.data_data_ok = 1'b1; dif.data_rdata = rd; phase = 2;
                end
                wcnt++;
            end
            @(negedge clk);
            if (stallreq) o.stall_cnt++;
            if (adel || ades) o.flag = 1;
            if (dif.data_req && !o.req_seen) begin
                o.req_seen = 1;
                o.addr = dif.data_addr; o.size = dif.data_size; o.wstrb = dif.data_wstrb;
                o.wdata = dif.data_wdata; o.wr = dif.data_wr;
            end
            if (ex_to_mem_bus[43]) begin
                if (o.done_cycles == 0) o.bus = ex_to_mem_bus;
                else if (ex_to_mem_bus !== o.bus) o.bus_stable = 0;
                o.done_cycles++;
                if (dif.data_req) o.done_req++;
                if (stall[3] == `NoStop) phase = 3;
            end
        end
        o.timeout = (phase != 3);
        @(posedge clk); #1;
        mem_valid = 1'b0; ld_code = 4'd0; st_size = 2'd0; stall = '0;
        dif.data_addr_ok = 1'b0; dif.data_data_ok = 1'b0;
        @(negedge clk);
        o.post_en = ex_to_mem_bus[43];
        o.post_req = dif.data_req;
        o.post_stall = stallreq;
        o.rdata_after = data_sram_rdata;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        rst = 1'b1; mem_valid = 1'b1; ld_code = 4'b1111; addr = 32'h0000_1000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (dif.data_req !== 1'b0) begin fails++; $display("FAIL reset_data_req got %b want 0", dif.data_req); end
        tests++; if (dif.data_wr !== 1'b0) begin fails++; $display("FAIL reset_data_wr got %b want 0", dif.data_wr); end
        tests++; if (dif.data_wstrb !== 4'b0000) begin fails++; $display("FAIL reset_wstrb got %b want 0000", dif.data_wstrb); end
        tests++; if (data_sram_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got %h want 0", data_sram_rdata); end
        tests++; if (stallreq !== 1'b0) begin fails++; $display("FAIL reset_stallreq got %b want 0", stallreq); end
        tests++; if ({adel, ades} !== 2'b00) begin fails++; $display("FAIL reset_adel_ades got %b want 00", {adel, ades}); end
        @(posedge clk); #1;
        rst = 1'b0; mem_valid = 1'b0; ld_code = 4'd0;
        @(negedge clk);
        tests++; if (dif.data_req !== 1'b0) begin fails++; $display("FAIL reset_release_req got %b want 0", dif.data_req); end
    endtask

    task automatic test_lw;
        obs_t o; exp_t e;
        exp_q.push_back('{addr: 32'h0000_1000, size: 2'd2, wstrb: 4'b0000, wdata: 32'd0, wr: 1'b0,
                          rdata: 32'hDEAD_BEEF, readen: 4'b1111, stall_cycles: 4});
        do_access(4'b1111, 2'b00, 32'h0000_1000, 32'h0, 0, 1, 32'hDEAD_BEEF, 0, o);
        e = exp_q.pop_front();
        tests++; if (o.timeout) begin fails++; $display("FAIL lw_timeout got timeout want DONE"); end
        tests++; if (o.stall_cnt != e.stall_cycles) begin fails++; $display("FAIL lw_stall_cycles got %0d want %0d", o.stall_cnt, e.stall_cycles); end
        tests++; if ({o.addr, o.size, o.wstrb, o.wr} !== {e.addr, e.size, e.wstrb, e.wr}) begin fails++; $display("FAIL lw_request got %h/%0d/%b/%b want %h/%0d/%b/%b", o.addr, o.size, o.wstrb, o.wr, e.addr, e.size, e.wstrb, e.wr); end
        tests++; if (o.rdata_after !== e.rdata) begin fails++; $display("FAIL lw_rdata got %h want %h", o.rdata_after, e.rdata); end
        tests++; if (o.bus[79:76] !== e.readen || o.bus[43] !== 1'b1 || o.bus[42:39] !== 4'b0000) begin fails++; $display("FAIL lw_bus_ctl got readen=%b en=%b wen=%b want %b/1/0000", o.bus[79:76], o.bus[43], o.bus[42:39], e.readen); end
        tests++; if (o.bus[31:0] !== 32'h0000_1000 || o.bus[75:44] !== 32'hBFC0_0100 || o.bus[36:32] !== 5'd9) begin fails++; $display("FAIL lw_bus_data got result=%h pc=%h waddr=%0d", o.bus[31:0], o.bus[75:44], o.bus[36:32]); end
        tests++; if (o.post_en !== 1'b0 || o.post_stall !== 1'b0) begin fails++; $display("FAIL lw_after got en=%b stallreq=%b want 0/0", o.post_en, o.post_stall); end
    endtask

    task automatic test_sb;
        obs_t o; exp_t e;
        exp_q.push_back('{addr: 32'h0000_2000, size: 2'd0, wstrb: 4'b1000, wdata: 32'hA5A5_A5A5, wr: 1'b1,
                          rdata: 32'd0, readen: 4'b0000, stall_cycles: 4});
        do_access(4'b0000, 2'b01, 32'h0000_2003, 32'h0000_00A5, 1, 0, 32'h0, 0, o);
        e = exp_q.pop_front();
        tests++; if (o.timeout) begin fails++; $display("FAIL sb_timeout got timeout want DONE"); end
        tests++; if ({o.addr, o.size, o.wstrb, o.wr} !== {e.addr, e.size, e.wstrb, e.wr}) begin fails++; $display("FAIL sb_request got %h/%0d/%b/%b want %h/%0d/%b/%b", o.addr, o.size, o.wstrb, o.wr, e.addr, e.size, e.wstrb, e.wr); end
        tests++; if (o.wdata !== e.wdata) begin fails++; $display("FAIL sb_wdata got %h want %h", o.wdata, e.wdata); end
        tests++; if (o.stall_cnt != e.stall_cycles) begin fails++; $display("FAIL sb_stall_cycles got %0d want %0d", o.stall_cnt, e.stall_cycles); end
        tests++; if (o.bus[42:39] !== e.wstrb || o.bus[79:76] !== e.readen) begin fails++; $display("FAIL sb_bus got wen=%b readen=%b want %b/%b", o.bus[42:39], o.bus[79:76], e.wstrb, e.readen); end
    endtask

    task automatic test_same_cycle;
        obs_t o; exp_t e;
        exp_q.push_back('{addr: 32'h0000_3000, size: 2'd1, wstrb: 4'b0000, wdata: 32'd0, wr: 1'b0,
                          rdata: 32'h0000_CAFE, readen: 4'b0011, stall_cycles: 2});
        do_access(4'b0011, 2'b00, 32'h0000_3002, 32'h0, 0, -1, 32'h0000_CAFE, 0, o);
        e = exp_q.pop_front();
        tests++; if (o.timeout) begin fails++; $display("FAIL lh_timeout got timeout want DONE"); end
        tests++; if (o.stall_cnt != e.stall_cycles) begin fails++; $display("FAIL lh_stall_cycles got %0d want %0d", o.stall_cnt, e.stall_cycles); end
        tests++; if ({o.addr, o.size} !== {e.addr, e.size}) begin fails++; $display("FAIL lh_request got %h/%0d want %h/%0d", o.addr, o.size, e.addr, e.size); end
        tests++; if (o.rdata_after !== e.rdata || o.bus[79:76] !== e.readen) begin fails++; $display("FAIL lh_result got rdata=%h readen=%b want %h/%b", o.rdata_after, o.bus[79:76], e.rdata, e.readen); end
    endtask

    task automatic test_done_hold;
        obs_t o;
        do_access(4'b1111, 2'b00, 32'h0000_1100, 32'h0, 0, 0, 32'h5555_AAAA, 3, o);
        tests++; if (o.timeout) begin fails++; $display("FAIL hold_timeout got timeout want DONE"); end
        tests++; if (o.done_cycles != 4) begin fails++; $display("FAIL hold_done_cycles got %0d want 4", o.done_cycles); end
        tests++; if (o.done_req != 0 || !o.bus_stable) begin fails++; $display("FAIL hold_bus got req_in_done=%0d stable=%0d want 0/1", o.done_req, o.bus_stable); end
        tests++; if (o.post_en !== 1'b0 || o.post_req !== 1'b0) begin fails++; $display("FAIL hold_release got en=%b req=%b want 0/0", o.post_en, o.post_req); end
    endtask

    task automatic test_back_to_back;
        obs_t o1, o2; exp_t e;
        exp_q.push_back('{addr: 32'h0000_6000, size: 2'd1, wstrb: 4'b1100, wdata: 32'hBEEF_BEEF, wr: 1'b1,
                          rdata: 32'd0, readen: 4'b0000, stall_cycles: 3});
        exp_q.push_back('{addr: 32'h0000_7000, size: 2'd0, wstrb: 4'b0000, wdata: 32'd0, wr: 1'b0,
                          rdata: 32'h1122_3344, readen: 4'b0010, stall_cycles: 3});
        do_access(4'b0000, 2'b10, 32'h0000_6002, 32'h1234_BEEF, 0, 0, 32'h0, 0, o1);
        do_access(4'b0010, 2'b00, 32'h0000_7001, 32'h0, 0, 0, 32'h1122_3344, 0, o2);
        e = exp_q.pop_front();
        tests++; if (o1.timeout || {o1.addr, o1.size, o1.wstrb, o1.wr, o1.wdata} !== {e.addr, e.size, e.wstrb, e.wr, e.wdata}) begin fails++; $display("FAIL sh_request got %h/%0d/%b/%b/%h want %h/%0d/%b/%b/%h", o1.addr, o1.size, o1.wstrb, o1.wr, o1.wdata, e.addr, e.size, e.wstrb, e.wr, e.wdata); end
        tests++; if (o1.stall_cnt != e.stall_cycles) begin fails++; $display("FAIL sh_stall_cycles got %0d want %0d", o1.stall_cnt, e.stall_cycles); end
        e = exp_q.pop_front();
        tests++; if (o2.timeout || {o2.addr, o2.size, o2.wstrb, o2.wr} !== {e.addr, e.size, e.wstrb, e.wr}) begin fails++; $display("FAIL lbu_request got %h/%0d/%b/%b want %h/%0d/%b/%b", o2.addr, o2.size, o2.wstrb, o2.wr, e.addr, e.size, e.wstrb, e.wr); end
        tests++; if (o2.rdata_after !== e.rdata || o2.bus[79:76] !== e.readen || o2.bus[31:0] !== 32'h0000_7001) begin fails++; $display("FAIL lbu_result got rdata=%h readen=%b result=%h want %h/%b/00007001", o2.rdata_after, o2.bus[79:76], o2.bus[31:0], e.rdata, e.readen); end
    endtask

    task automatic test_no_access;
        @(posedge clk); #1;
        mem_valid = 1'b1; ld_code = 4'd0; st_size = 2'd0; alu_result = 32'h0BAD_F00D;
        dif.data_data_ok = 1'b1; dif.data_addr_ok = 1'b1; dif.data_rdata = 32'hFFFF_0000;
        @(negedge clk);
        tests++; if (stallreq !== 1'b0 || ex_to_mem_bus[43] !== 1'b0 || ex_to_mem_bus[31:0] !== 32'h0BAD_F00D) begin fails++; $display("FAIL no_access_bus got stallreq=%b en=%b result=%h want 0/0/0badf00d", stallreq, ex_to_mem_bus[43], ex_to_mem_bus[31:0]); end
        @(posedge clk); #1;
        dif.data_data_ok = 1'b0; dif.data_addr_ok = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        tests++; if (data_sram_rdata !== 32'h1122_3344 || dif.data_req !== 1'b0) begin fails++; $display("FAIL idle_data_ok_ignored got rdata=%h req=%b want 11223344/0", data_sram_rdata, dif.data_req); end
    endtask

    task automatic test_reset_wait;
        @(posedge clk); #1;
        mem_valid = 1'b1; ld_code = 4'b1111; st_size = 2'd0; addr = 32'h0000_5000; stall = '0;
        @(posedge clk); #1;
        dif.data_addr_ok = dif.data_req;
        @(negedge clk);
        tests++; if (dif.data_req !== 1'b1) begin fails++; $display("FAIL rstwait_req got %b want 1", dif.data_req); end
        @(posedge clk); #1;
        dif.data_addr_ok = 1'b0; rst = 1'b1; mem_valid = 1'b0; ld_code = 4'd0;
        @(negedge clk);
        tests++; if (stallreq !== 1'b0 || dif.data_req !== 1'b0) begin fails++; $display("FAIL rstwait_in_reset got stallreq=%b req=%b want 0/0", stallreq, dif.data_req); end
        @(posedge clk); #1;
        rst = 1'b0; dif.data_data_ok = 1'b1; dif.data_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        dif.data_data_ok = 1'b0;
        @(negedge clk);
        tests++; if (data_sram_rdata !== 32'd0 || stallreq !== 1'b0 || ex_to_mem_bus[43] !== 1'b0) begin fails++; $display("FAIL rstwait_after got rdata=%h stallreq=%b en=%b want 0/0/0", data_sram_rdata, stallreq, ex_to_mem_bus[43]); end
    endtask

    task automatic test_align;
`ifdef LSU_ALIGN_CHECK_EN
        @(posedge clk); #1;
        mem_valid = 1'b1; ld_code = 4'd0; st_size = 2'b11; addr = 32'h0000_4001; rf_we = 1'b1; stall = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if ({ades, adel, dif.data_req, stallreq, ex_to_mem_bus[43], ex_to_mem_bus[37]} !== 6'b100000) begin fails++; $display("FAIL sw_misaligned got ades=%b adel=%b req=%b stallreq=%b en=%b rf_we=%b want 1/0/0/0/0/0", ades, adel, dif.data_req, stallreq, ex_to_mem_bus[43], ex_to_mem_bus[37]); end
            @(posedge clk); #1;
        end
        st_size = 2'd0; ld_code = 4'b1111; addr = 32'h0000_1002;
        @(negedge clk);
        tests++; if ({adel, ades, stallreq} !== 3'b100) begin fails++; $display("FAIL lw_misaligned got adel=%b ades=%b stallreq=%b want 1/0/0", adel, ades, stallreq); end
        @(posedge clk); #1;
        mem_valid = 1'b0; ld_code = 4'd0;
        @(negedge clk);
`else
        obs_t o;
        do_access(4'b0000, 2'b11, 32'h0000_4001, 32'h0102_0304, 0, 0, 32'h0, 0, o);
        tests++; if (o.timeout || !o.req_seen) begin fails++; $display("FAIL sw_unaligned_issue got req_seen=%0d timeout=%0d want 1/0", o.req_seen, o.timeout); end
        tests++; if ({o.wstrb, o.addr, o.wr} !== {4'b1111, 32'h0000_4000, 1'b1}) begin fails++; $display("FAIL sw_unaligned_req got %b/%h/%b want 1111/00004000/1", o.wstrb, o.addr, o.wr); end
        tests++; if (o.flag) begin fails++; $display("FAIL sw_unaligned_flags got adel|ades=1 want 0"); end
`endif
    endtask

    initial begin
        rst = 1'b1; stall = '0; mem_valid = 1'b0; ld_code = 4'd0; st_size = 2'd0;
        ex_pc = 32'd0; addr = 32'd0; st_data = 32'd0; alu_result = 32'd0;
        sel_rf_res = 1'b0; rf_we = 1'b0; rf_waddr = 5'd0;
        dif.data_addr_ok = 1'b0; dif.data_data_ok = 1'b0; dif.data_rdata = 32'd0;
        test_reset();
        test_lw();
        test_sb();
        test_same_cycle();
        test_done_hold();
        test_back_to_back();
        test_no_access();
        test_reset_wait();
        test_align();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
